axi_multi_chan_logger: RTL and testbench

AXI_MULTI_CHAN_LOGGER -- requirements
Module: axi_multi_chan_logger

---
 rtl/axi_multi_chan_logger.sv | 117 +++++++++++
 tb/tb_axi_multi_chan_logger.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_multi_chan_logger.sv
// axi_multi_chan_logger: timestamps AXI address handshakes from several channels
// and stores them through a round-robin arbiter into a stop-when-full or circular log RAM.
module axi_multi_chan_logger #(
  parameter int NUM_CH         = 2,
  parameter int AXI_ADDR_BITW  = 32,
  parameter int AXI_ID_BITW    = 8,
  parameter int AXI_LEN_BITW   = 8,
  parameter int TIMESTAMP_BITW = 32,
  parameter int DEPTH          = 1024,
  parameter int AFULL_MARGIN   = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int EW = TIMESTAMP_BITW + AXI_ADDR_BITW + AXI_ID_BITW + AXI_LEN_BITW + CW
) (
  input  logic                                   Clk_CI,
  input  logic                                   Rst_RI,
  input  logic [NUM_CH-1:0]                      AxiValid_SI,
  input  logic [NUM_CH-1:0]                      AxiReady_SI,
  input  logic [NUM_CH-1:0][AXI_ID_BITW-1:0]     AxiId_DI,
  input  logic [NUM_CH-1:0][AXI_ADDR_BITW-1:0]   AxiAddr_DI,
  input  logic [NUM_CH-1:0][AXI_LEN_BITW-1:0]    AxiLen_DI,
  input  logic                                   Enable_SI,
  input  logic                                   Wrap_SI,
  input  logic                                   Clear_SI,
  input  logic                                   RdEn_SI,
  input  logic [AW-1:0]                          RdAddr_DI,
  output logic [EW-1:0]                          RdData_DO,
  output logic [AW:0]                            Count_DO,
  output logic [AW-1:0]                          WrPtr_DO,
  output logic                                   Full_SO,
  output logic                                   AlmostFull_SO,
  output logic                                   Wrapped_SO,
  output logic [15:0]                            DropCnt_DO
);
  logic [EW-1:0] mem [DEPTH];
  logic [NUM_CH-1:0] pend_vld_q, pend_vld_d, hs, gnt, drop, load;
  logic [NUM_CH-1:0][EW-1:0] pend_q, pend_d;
  logic [CW-1:0] rr_q, rr_d, gnt_idx;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [TIMESTAMP_BITW-1:0] ts_q, ts_d;
  logic [15:0] drop_q, drop_d;
  logic [16:0] drop_sum;
  logic [EW-1:0] rd_q, rd_d;
  logic wrapped_q, wrapped_d, gnt_vld, can_wr, full;

  assign full = count_q == (AW+1)'(DEPTH);

  // Round-robin: walk offsets high to low so the lowest offset from rr_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    can_wr  = Wrap_SI || !full;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_vld_q[(int'(rr_q) + i) % NUM_CH] && can_wr) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'((int'(rr_q) + i) % NUM_CH);
      end
    end
    gnt = gnt_vld ? NUM_CH'(1) << gnt_idx : '0;
  end

  always_comb begin
    drop_sum = {1'b0, drop_q};
    for (int c = 0; c < NUM_CH; c++) begin
      hs[c]         = AxiValid_SI[c] & AxiReady_SI[c] & Enable_SI & ~Clear_SI;
      load[c]       = hs[c] & (~pend_vld_q[c] | gnt[c]);
      drop[c]       = hs[c] & ~load[c];
      pend_vld_d[c] = ~Clear_SI & (load[c] | (pend_vld_q[c] & ~gnt[c]));
      pend_d[c]     = load[c] ? {CW'(c), AxiLen_DI[c], AxiId_DI[c], AxiAddr_DI[c], ts_q} : pend_q[c];
      drop_sum      = drop_sum + 17'(drop[c]);
    end
    drop_d    = Clear_SI ? '0 : drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    rr_d      = Clear_SI ? '0 : gnt_vld ? CW'((int'(gnt_idx) + 1) % NUM_CH) : rr_q;
    wr_ptr_d  = Clear_SI ? '0 : wr_ptr_q + AW'(gnt_vld);
    count_d   = Clear_SI ? '0 : count_q + (AW+1)'(gnt_vld && !full);
    wrapped_d = ~Clear_SI & (wrapped_q | (gnt_vld & full));
    ts_d      = Clear_SI ? '0 : ts_q + 1'b1;
    rd_d      = RdEn_SI ? mem[RdAddr_DI] : rd_q;
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      pend_vld_q <= '0;
      pend_q     <= '0;
      rr_q       <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      wrapped_q  <= 1'b0;
      ts_q       <= '0;
      rd_q       <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      wrapped_q  <= wrapped_d;
      ts_q       <= ts_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (gnt_vld && !Clear_SI) mem[wr_ptr_q] <= pend_q[gnt_idx];
  end

  assign RdData_DO     = rd_q;
  assign Count_DO      = count_q;
  assign WrPtr_DO      = wr_ptr_q;
  assign Full_SO       = full;
  assign AlmostFull_SO = int'(count_q) >= DEPTH - AFULL_MARGIN;
  assign Wrapped_SO    = wrapped_q;
  assign DropCnt_DO    = drop_q;
endmodule

// File: tb/tb_axi_multi_chan_logger.sv
// tb_axi_multi_chan_logger: scoreboard bench for the logger with a small 2-channel, 8-entry log.
module tb_axi_multi_chan_logger;
  localparam int NCH = 2, ABW = 16, IBW = 4, LBW = 4, TSW = 16, DEP = 8, AFM = 2, AW = 3, CW = 1;
  localparam int EW = TSW + ABW + IBW + LBW + CW;
  logic clk = 1'b0, rst = 1'b1;
  logic [NCH-1:0] valid = '0, ready = '1;
  logic [NCH-1:0][IBW-1:0] id = '0;
  logic [NCH-1:0][ABW-1:0] addr = '0;
  logic [NCH-1:0][LBW-1:0] len = '0;
  logic en = 1'b1, wrap = 1'b0, clr = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [EW-1:0] rd_data, last_exp, keep6;
  logic [AW:0] count;
  logic [AW-1:0] wr_ptr;
  logic full, afull, wrapped;
  logic [15:0] drop_cnt;
  logic [TSW-1:0] cyc;
  logic [EW-1:0] sb[$];
  int checks = 0, failures = 0, t0;

  axi_multi_chan_logger #(.NUM_CH(NCH), .AXI_ADDR_BITW(ABW), .AXI_ID_BITW(IBW), .AXI_LEN_BITW(LBW),
    .TIMESTAMP_BITW(TSW), .DEPTH(DEP), .AFULL_MARGIN(AFM)) dut (
    .Clk_CI(clk), .Rst_RI(rst), .AxiValid_SI(valid), .AxiReady_SI(ready), .AxiId_DI(id),
    .AxiAddr_DI(addr), .AxiLen_DI(len), .Enable_SI(en), .Wrap_SI(wrap), .Clear_SI(clr),
    .RdEn_SI(rd_en), .RdAddr_DI(rd_addr), .RdData_DO(rd_data), .Count_DO(count),
    .WrPtr_DO(wr_ptr), .Full_SO(full), .AlmostFull_SO(afull), .Wrapped_SO(wrapped),
    .DropCnt_DO(drop_cnt));

  always #5 clk = ~clk;

  // Expected logger timestamp for the current cycle.
  always @(posedge clk or posedge rst) cyc <= rst ? '0 : clr ? '0 : cyc + 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] ent(input int ch, input int ts, input int k);
    return {CW'(ch), LBW'(k), IBW'(k + ch), ABW'(4096 * (ch + 1) + k), TSW'(ts)};
  endfunction

  task automatic put(input int ch, input int k);
    valid[ch] = 1'b1;
    addr[ch]  = ABW'(4096 * (ch + 1) + k);
    id[ch]    = IBW'(k + ch);
    len[ch]   = LBW'(k);
  endtask

  task automatic log_push(input logic [EW-1:0] e);
    if (sb.size() == DEP) void'(sb.pop_front());
    sb.push_back(e);
  endtask

  task automatic read_chk(input int slot, input string tag);
    rd_en = 1'b1;
    rd_addr = AW'(slot);
    tick();
    rd_en = 1'b0;
    last_exp = sb.pop_front();
    check($sformatf("%s_slot%0d", tag, slot), 64'(rd_data), 64'(last_exp));
  endtask

  task automatic drain_all(input int start, input string tag);
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) read_chk((start + i) % DEP, tag);
  endtask

  initial begin
    tick(3);
    check("rst_count", 64'(count), 0);
    check("rst_wrptr", 64'(wr_ptr), 0);
    check("rst_full", 64'(full), 0);
    check("rst_afull", 64'(afull), 0);
    check("rst_wrapped", 64'(wrapped), 0);
    check("rst_drop", 64'(drop_cnt), 0);
    check("rst_rddata", 64'(rd_data), 0);
    rst = 1'b0;
    // single channel, handshakes at timestamps 5,6,7; ready low at ts 4 is no handshake
    for (int i = 0; i < 20 && cyc != 4; i++) tick();
    ready[0] = 1'b0;
    put(0, 0);
    tick();
    ready[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      log_push(ent(0, cyc, k));
      put(0, k);
      tick();
    end
    valid = '0;
    tick(2);
    check("a_count", 64'(count), 3);
    check("a_wrptr", 64'(wr_ptr), 3);
    drain_all(0, "a_rd");
    tick(2);
    check("a_rd_hold", 64'(rd_data), 64'(last_exp));
    // clear keeps memory; then simultaneous traffic on both channels
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("b_clr_count", 64'(count), 0);
    check("b_clr_wrptr", 64'(wr_ptr), 0);
    sb.push_back(last_exp);
    read_chk(2, "b_keep");
    t0 = int'(cyc);
    log_push(ent(0, t0, 0));
    log_push(ent(1, t0, 0));
    log_push(ent(0, t0 + 1, 1));
    log_push(ent(1, t0 + 2, 2));
    log_push(ent(0, t0 + 3, 3));
    for (int k = 0; k < 4; k++) begin
      put(0, k);
      put(1, k);
      tick();
    end
    valid = '0;
    tick(3);
    check("b_drop", 64'(drop_cnt), 3);
    check("b_count", 64'(count), 5);
    check("b_wrptr", 64'(wr_ptr), 5);
    check("b_afull", 64'(afull), 0);
    drain_all(0, "b_rd");
    // stop-when-full
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 9) log_push(ent(0, cyc, k));
      put(0, k);
      tick();
      valid = '0;
      tick();
      if (k <= 8) begin
        check($sformatf("c_count_%0d", k), 64'(count), 64'(k));
        check($sformatf("c_afull_%0d", k), 64'(afull), 64'(k >= DEP - AFM));
      end
    end
    check("c_full", 64'(full), 1);
    check("c_count_full", 64'(count), 8);
    check("c_drop", 64'(drop_cnt), 1);
    check("c_wrapped_stop", 64'(wrapped), 0);
    check("c_wrptr_stop", 64'(wr_ptr), 0);
    wrap = 1'b1;
    tick();
    check("c_wrapped", 64'(wrapped), 1);
    check("c_wrptr", 64'(wr_ptr), 1);
    check("c_count_wrap", 64'(count), 8);
    drain_all(1, "c_rd");
    // circular mode, 18 events into 8 slots
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      log_push(ent(1, cyc, k));
      put(1, k);
      tick();
      valid = '0;
      tick();
      check($sformatf("d_wrapped_%0d", k), 64'(wrapped), 64'(k > DEP));
    end
    check("d_count", 64'(count), 8);
    check("d_wrptr", 64'(wr_ptr), 2);
    check("d_full", 64'(full), 1);
    check("d_drop", 64'(drop_cnt), 0);
    keep6 = sb[4];
    drain_all(2, "d_rd");
    // clear on the same cycle as a handshake, after a drop
    put(0, 20);
    put(1, 20);
    tick();
    tick();
    valid = '0;
    tick(3);
    check("e_drop_pre", 64'(drop_cnt), 1);
    clr = 1'b1;
    put(0, 21);
    tick();
    clr = 1'b0;
    put(0, 22);
    sb.push_back(ent(0, 0, 22));
    check("e_count", 64'(count), 0);
    check("e_drop", 64'(drop_cnt), 0);
    check("e_wrptr", 64'(wr_ptr), 0);
    check("e_wrapped", 64'(wrapped), 0);
    tick();
    valid = '0;
    tick();
    check("e_count_one", 64'(count), 1);
    read_chk(0, "e_ts0");
    sb.push_back(keep6);
    read_chk(6, "e_keep");
    en = 1'b0;
    put(0, 24);
    tick();
    valid = '0;
    tick();
    check("e_en_off", 64'(count), 1);
    en = 1'b1;
    put(0, 25);
    tick();
    en = 1'b0;
    valid = '0;
    tick();
    check("e_en_drain", 64'(count), 2);
    en = 1'b1;
    // asynchronous reset with an entry pending
    put(0, 26);
    tick();
    valid = '0;
    #2 rst = 1'b1;
    #1;
    check("f_count", 64'(count), 0);
    check("f_wrptr", 64'(wr_ptr), 0);
    check("f_rddata", 64'(rd_data), 0);
    check("f_full", 64'(full), 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    check("f_count_post", 64'(count), 0);
    check("f_wrptr_post", 64'(wr_ptr), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
